// File: rtl/sram_fifo_ctrl_pkg.sv
// rtl/sram_fifo_ctrl_pkg.sv - shared sizes and types for the SRAM-backed FIFO controller
package fifo_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int NUM_WMASKS = 4;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    // Width able to hold every occupancy value from 0 up to RAM_DEPTH+2.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 3);
    endfunction

    localparam int CNT_WIDTH = cnt_width(RAM_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// rtl/sram_fifo_ctrl_if.sv - write and read valid/ready streams of the FIFO controller
interface sram_fifo_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    // Producer/consumer side.
    modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
    // FIFO side.
    modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/sram_fifo_ctrl_out_buf.sv
// rtl/sram_fifo_ctrl_out_buf.sv - 2-entry in-order prefetch buffer giving first-word-fall-through
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    cnt
);
    logic [DW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_pop;

    assign do_pop = pop & (cnt_q != 2'd0);
    assign dout   = ent0_q;
    assign valid  = (cnt_q != 2'd0);
    assign cnt    = cnt_q;

    // Next entries: ent0 is always the head; a pop shifts ent1 forward.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else begin
            case ({load, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_d = din;
                    else               ent1_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_d = din;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - single-clock FIFO controller over a 1rw1r SRAM macro
module sram_fifo_ctrl
    import fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    sram_fifo_ctrl_if.slave       s_if,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output addr_t                 sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output addr_t                 sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam int CW = ADDR_WIDTH + 2;

    addr_t                wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           ob_cnt;
    logic [2:0]           ob_pending;
    logic                 wr_ready_w, push, pop, fetch, ob_valid;
    logic [DATA_WIDTH-1:0] ob_data;

    // Readiness uses the registered SRAM occupancy, so a same-cycle fetch never raises it.
    assign wr_ready_w = rst_n & (mem_cnt_q < CNT_WIDTH'(RAM_DEPTH)) & ~flush;
    assign push       = s_if.wr_valid & wr_ready_w;
    assign pop        = ob_valid & s_if.rd_ready;
    // Slots the buffer will have committed after this edge; a fetch needs one free.
    assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch      = (mem_cnt_q != '0) & (ob_pending < 3'd2) & ~flush;

    assign s_if.wr_ready = wr_ready_w;
    assign s_if.rd_valid = ob_valid;
    assign s_if.rd_data  = ob_data;

    assign sram_csb0   = ~push;
    assign sram_web0   = 1'b0;
    assign sram_wmask0 = '1;
    assign sram_addr0  = wptr_q;
    assign sram_din0   = s_if.wr_data;
    assign sram_csb1   = ~fetch;
    assign sram_addr1  = rptr_q;

    assign count = CW'(mem_cnt_q) + CW'(inflight_q) + CW'(ob_cnt);

    // Pointer and counter next state; flush drops everything including the returning word.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_cnt_d  = mem_cnt_q;
        inflight_d = inflight_q;
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            mem_cnt_d  = '0;
            inflight_d = 1'b0;
        end else begin
            wptr_d     = wptr_q + addr_t'(push);
            rptr_d     = rptr_q + addr_t'(fetch);
            mem_cnt_d  = mem_cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(fetch);
            inflight_d = fetch;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_out_buf #(.DW(DATA_WIDTH)) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .load  (inflight_q & ~flush),
        .din   (sram_dout1),
        .pop   (pop),
        .dout  (ob_data),
        .valid (ob_valid),
        .cnt   (ob_cnt)
    );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - randomized and directed bench for sram_fifo_ctrl with a queue-based model
module tb_sram_fifo_ctrl;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, flush;
    logic [ADDR_WIDTH+1:0] count;
    logic                  sram_csb0, sram_web0, sram_csb1;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    addr_t                 sram_addr0, sram_addr1;
    logic [DATA_WIDTH-1:0] sram_din0, sram_dout1;

    sram_fifo_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) fif ();

    sram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .s_if(fif), .count(count),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // SRAM macro: inputs registered at posedge, array accessed at negedge.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  lat_csb0 = 1'b1, lat_csb1 = 1'b1;
    addr_t                 lat_addr0, lat_addr1;
    logic [DATA_WIDTH-1:0] lat_din0;
    always @(posedge clk) begin
        lat_csb0  <= sram_csb0;
        lat_addr0 <= sram_addr0;
        lat_din0  <= sram_din0;
        lat_csb1  <= sram_csb1;
        lat_addr1 <= sram_addr1;
    end
    always @(negedge clk) begin
        if (!lat_csb0) mem[lat_addr0] <= lat_din0;
        if (!lat_csb1) sram_dout1 <= mem[lat_addr1];
    end

    // Behavioural model: words waiting in SRAM, one word on its way back, buffered words.
    logic [DATA_WIDTH-1:0] mq[$];
    logic [DATA_WIDTH-1:0] obq[$];
    bit                    m_infl;
    logic [DATA_WIDTH-1:0] m_infl_w;
    int                    m_wptr, m_rptr;

    int vectors = 0, miscompares = 0;
    logic                  obs_rv, obs_wrr, obs_csb1;
    logic [DATA_WIDTH-1:0] obs_rd;
    logic [ADDR_WIDTH+1:0] obs_cnt;
    addr_t                 obs_addr1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        obq.delete();
        m_infl = 1'b0;
        m_wptr = 0;
        m_rptr = 0;
    endtask

    // One clock cycle: drive, compare against the model, take the edge, advance the model.
    task automatic cycle(input bit wv, input logic [31:0] wd, input bit rr, input bit fl);
        bit e_wrr, e_push, e_pop, e_fetch, e_load;
        int pend;
        fif.wr_valid = wv;
        fif.wr_data  = wd;
        fif.rd_ready = rr;
        flush        = fl;
        #2;
        e_wrr   = rst_n && (mq.size() < RAM_DEPTH) && !fl;
        e_push  = wv && e_wrr;
        e_pop   = (obq.size() > 0) && rr;
        pend    = obq.size() + int'(m_infl) - int'(e_pop);
        e_fetch = rst_n && (mq.size() > 0) && (pend < 2) && !fl;
        chk("wr_ready", fif.wr_ready, e_wrr);
        chk("rd_valid", fif.rd_valid, obq.size() > 0);
        if (obq.size() > 0) chk("rd_data", fif.rd_data, obq[0]);
        chk("count", count, mq.size() + int'(m_infl) + obq.size());
        chk("count_max", count <= RAM_DEPTH + 2, 1);
        chk("csb0", sram_csb0, !e_push);
        chk("csb1", sram_csb1, !e_fetch);
        chk("tied", {sram_web0, sram_wmask0}, {1'b0, {NUM_WMASKS{1'b1}}});
        if (e_push) begin
            chk("addr0", sram_addr0, m_wptr);
            chk("din0", sram_din0, wd);
        end
        if (e_fetch) chk("addr1", sram_addr1, m_rptr);
        obs_rv = fif.rd_valid; obs_rd = fif.rd_data; obs_wrr = fif.wr_ready;
        obs_cnt = count; obs_csb1 = sram_csb1; obs_addr1 = sram_addr1;
        @(posedge clk);
        if (!rst_n || fl) begin
            model_clear();
        end else begin
            e_load = m_infl;
            if (e_pop) void'(obq.pop_front());
            if (e_load) obq.push_back(m_infl_w);
            if (e_fetch) begin
                m_infl_w = mq.pop_front();
                m_rptr = (m_rptr + 1) % RAM_DEPTH;
            end
            m_infl = e_fetch;
            if (e_push) begin
                mq.push_back(wd);
                m_wptr = (m_wptr + 1) % RAM_DEPTH;
            end
        end
        #1;
    endtask

    initial begin
        int rx, gaps, pushed;
        rst_n = 1'b0; flush = 1'b0;
        fif.wr_valid = 1'b0; fif.wr_data = '0; fif.rd_ready = 1'b0;
        model_clear();

        // Reset and idle.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        chk("reset_wr_ready", obs_wrr, 0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("idle_wr_ready", obs_wrr, 1);
        chk("idle_rd_valid", obs_rv, 0);
        chk("idle_count", obs_cnt, 0);
        chk("idle_csb1", obs_csb1, 1);

        // Single word latency.
        cycle(1, 32'hA5A5_0001, 0, 0);
        cycle(0, 0, 0, 0);
        chk("lat_csb1", obs_csb1, 0);
        chk("lat_addr1", obs_addr1, 0);
        cycle(0, 0, 0, 0);
        chk("lat_not_yet", obs_rv, 0);
        cycle(0, 0, 0, 0);
        chk("lat_rd_valid", obs_rv, 1);
        chk("lat_rd_data", obs_rd, 32'hA5A5_0001);
        chk("lat_count", obs_cnt, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("lat_empty", obs_cnt, 0);

        // Stream 1000 words at full rate.
        rx = 0; gaps = 0;
        for (int i = 0; i < 1006; i++) begin
            cycle(i < 1000, i, 1, 0);
            if (obs_rv) begin
                chk("stream_order", obs_rd, rx);
                rx++;
            end else if (i >= 3 && i <= 1002) begin
                gaps++;
            end
        end
        chk("stream_rx", rx, 1000);
        chk("stream_gaps", gaps, 0);

        // Fill until full with the consumer stalled, then drain.
        pushed = 0;
        for (int i = 0; i < 300 && pushed < 400; i++) begin
            cycle(1, pushed, 0, 0);
            if (!obs_wrr) break;
            pushed++;
        end
        chk("fill_pushed", pushed, RAM_DEPTH + 2);
        cycle(1, 32'hDEAD_BEEF, 0, 0);
        chk("full_count", obs_cnt, RAM_DEPTH + 2);
        chk("full_wr_ready", obs_wrr, 0);
        cycle(0, 0, 0, 0);
        chk("full_ignored", obs_cnt, RAM_DEPTH + 2);
        rx = 0;
        for (int i = 0; i < 280; i++) begin
            cycle(0, 0, 1, 0);
            if (obs_rv) begin
                chk("drain_order", obs_rd, rx);
                rx++;
            end
        end
        chk("drain_rx", rx, RAM_DEPTH + 2);

        // Random traffic with occasional flush and one mid-run reset.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                #1 rst_n = 1'b0;
                model_clear();
                cycle(0, 0, 0, 0);
                rst_n = 1'b1;
            end
            cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 999) == 0);
        end

        // Flush with a fetch in flight.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 32'h100 + i, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("flush_count", obs_cnt, 0);
        chk("flush_rd_valid", obs_rv, 0);
        cycle(1, 32'h1234, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("post_flush_data", obs_rd, 32'h1234);
        chk("post_flush_count", obs_cnt, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("post_flush_empty", obs_rv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
